// File: rtl/r_alu_ctrl_pkg.sv
// Shared decode constants and the packed control word for the R-format ALU control queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package r_alu_ctrl_pkg;

    // R-format opcodes, i[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_ANDS = 11'b11101010000;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;

    // ALU function select codes
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    // PC select and bus enable encodings
    localparam logic [1:0] PS_PC4 = 2'b01;
    localparam logic [1:0] EN_ALU = 2'b01;

    // Compact control word as stored in the queue. Register fields and shamt keep
    // their instruction widths; the top resizes them to REG_AW / DATA_W on the way out.
    typedef struct packed {
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fs;
        logic [5:0] shamt;
        logic [1:0] ps;
        logic [1:0] en;
        logic       reg_write;
        logic       mem_write;
        logic       pc_sel;
        logic       b_sel;
        logic       status_load;
        logic       state;
        logic       illegal;
    } ctrl_word_t;

    // Idle word: advance the PC, ALU onto the bus, no architectural side effects.
    localparam ctrl_word_t CW_NOP = '{
        da: 5'd0, sa: 5'd0, sb: 5'd0, fs: 5'd0, shamt: 6'd0,
        ps: PS_PC4, en: EN_ALU,
        reg_write: 1'b0, mem_write: 1'b0, pc_sel: 1'b0, b_sel: 1'b0,
        status_load: 1'b0, state: 1'b0, illegal: 1'b0
    };

endpackage

// File: rtl/r_alu_ctrl_queue_decode.sv
// Decodes one R-format instruction word into a control word; unknown opcodes give NOP + illegal.
// Latency: purely combinational.
// Backpressure: none; the queue decides whether the decoded word is stored.
module r_alu_decode
    import r_alu_ctrl_pkg::*;
(
    input  logic [31:0] i,
    output ctrl_word_t  cw
);

    logic [10:0] opcode;
    assign opcode = i[31:21];

    // Opcode lookup, then register and shamt fields for every legal instruction
    always_comb begin
        cw = CW_NOP;
        cw.reg_write = 1'b1;
        cw.da        = i[4:0];
        cw.sa        = i[9:5];
        cw.sb        = i[20:16];
        unique case (opcode)
            OP_ADD:  cw.fs = FS_ADD;
            OP_SUB:  cw.fs = FS_SUB;
            OP_ADDS: begin cw.fs = FS_ADD; cw.status_load = 1'b1; end
            OP_SUBS: begin cw.fs = FS_SUB; cw.status_load = 1'b1; end
            OP_AND:  cw.fs = FS_AND;
            OP_ORR:  cw.fs = FS_ORR;
            OP_EOR:  cw.fs = FS_EOR;
            OP_ANDS: begin cw.fs = FS_AND; cw.status_load = 1'b1; end
            OP_LSR:  begin cw.fs = FS_LSR; cw.b_sel = 1'b1; cw.shamt = i[15:10]; end
            OP_LSL:  begin cw.fs = FS_LSL; cw.b_sel = 1'b1; cw.shamt = i[15:10]; end
            default: begin
                cw         = CW_NOP;
                cw.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/r_alu_ctrl_queue.sv
// Decodes R-format ALU instructions and queues control words (OUT_DEPTH entries) for the datapath.
// Latency: accepted word is at the head one edge later when the queue was empty.
// Backpressure: i_ready = not full, registered state only; full + pop does not refill that cycle.
// Optional statistics ports/counters are built when R_ALU_CTRL_STATS_EN is defined.
module r_alu_ctrl_queue
    import r_alu_ctrl_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int REG_AW    = 5,
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [31:0]       i,
    input  logic              flush,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [REG_AW-1:0] DA,
    output logic [REG_AW-1:0] SA,
    output logic [REG_AW-1:0] SB,
    output logic [4:0]        FS,
    output logic [DATA_W-1:0] k,
    output logic [1:0]        PS,
    output logic [1:0]        enable,
    output logic              regWrite,
    output logic              memWrite,
    output logic              PC_sel,
    output logic              B_sel,
    output logic              status_load,
    output logic              state,
    output logic              illegal
`ifdef R_ALU_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
`endif
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_QW = $clog2(OUT_DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(OUT_DEPTH - 1);
    localparam logic [CNT_QW-1:0] CNT_FULL = CNT_QW'(OUT_DEPTH);

    ctrl_word_t dec_cw;
    ctrl_word_t head_cw;

    ctrl_word_t        mem_q [OUT_DEPTH];
    ctrl_word_t        mem_d [OUT_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_QW-1:0] count_q, count_d;

    logic push;
    logic pop;

    r_alu_decode u_decode (
        .i  (i),
        .cw (dec_cw)
    );

    // Handshakes; flush swallows whatever completes in its cycle
    assign i_ready = (count_q < CNT_FULL);
    assign o_valid = (count_q != '0);
    assign push    = i_valid && i_ready && !flush;
    assign pop     = o_valid && o_ready && !flush;

    // Next-state for storage, pointers (modulo OUT_DEPTH) and occupancy
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = dec_cw;
                tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
            end
            if (pop) begin
                head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < OUT_DEPTH; n++) begin
                mem_q[n] <= CW_NOP;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Head entry drives the outputs; an empty queue shows the idle word
    always_comb begin
        head_cw = CW_NOP;
        if (o_valid) begin
            head_cw = mem_q[head_q];
        end
    end

    assign DA          = REG_AW'(head_cw.da);
    assign SA          = REG_AW'(head_cw.sa);
    assign SB          = REG_AW'(head_cw.sb);
    assign FS          = head_cw.fs;
    assign k           = DATA_W'(head_cw.shamt);
    assign PS          = head_cw.ps;
    assign enable      = head_cw.en;
    assign regWrite    = head_cw.reg_write;
    assign memWrite    = head_cw.mem_write;
    assign PC_sel      = head_cw.pc_sel;
    assign B_sel       = head_cw.b_sel;
    assign status_load = head_cw.status_load;
    assign state       = head_cw.state;
    assign illegal     = head_cw.illegal;

`ifdef R_ALU_CTRL_STATS_EN
    logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
    logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

    // Saturating pop counters, split by the popped entry's illegal flag
    always_comb begin
        issued_cnt_d  = issued_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        if (pop) begin
            if (head_cw.illegal) begin
                if (illegal_cnt_q != '1) illegal_cnt_d = illegal_cnt_q + 1'b1;
            end else begin
                if (issued_cnt_q != '1) issued_cnt_d = issued_cnt_q + 1'b1;
            end
        end
    end

    // Statistics registers; only reset clears them
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issued_cnt_q  <= '0;
            illegal_cnt_q <= '0;
        end else begin
            issued_cnt_q  <= issued_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign issued_cnt  = issued_cnt_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
